// File: rtl/tron_game_ctrl.sv
// tron_game_ctrl
//   Round/match sequencer for two-player Tron. Arbitrates joystick heading
//   requests into one committed heading per frame, scores crashes, and runs
//   IDLE -> COUNTDOWN -> PLAY -> ROUND_OVER -> (COUNTDOWN | GAME_OVER).
//   Every decision is aligned to frame_tick. All outputs are registered.
// Ports
//   clock, reset             single clock, synchronous active-high reset
//   frame_tick               1-cycle pulse per video frame
//   start                    start/restart request (level)
//   p1/p2_dir_in, _valid     heading requests: 000 UP, 001 DOWN, 010 LEFT, 011 RIGHT
//   p1/p2_crash              crash indications, any cycle
//   dflt                     hold players at their start positions
//   p1/p2_info               committed heading in PLAY, 100 (STOP) otherwise
//   p1/p2_score              rounds won, saturating at WIN_SCORE
//   round_winner             00 none, 01 p1, 10 p2, 11 draw
//   game_over                high while in GAME_OVER
//   state_out                current state code
module tron_game_ctrl #(
  parameter int COUNTDOWN_FRAMES = 120,
  parameter int ROUNDOVER_FRAMES = 90,
  parameter int WIN_SCORE        = 3,
  parameter int SCORE_W          = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [2:0]         p1_dir_in,
  input  logic               p1_dir_valid,
  input  logic [2:0]         p2_dir_in,
  input  logic               p2_dir_valid,
  input  logic               p1_crash,
  input  logic               p2_crash,
  output logic               dflt,
  output logic [2:0]         p1_info,
  output logic [2:0]         p2_info,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         round_winner,
  output logic               game_over,
  output logic [2:0]         state_out
);

  localparam int MAX_FRAMES = (COUNTDOWN_FRAMES > ROUNDOVER_FRAMES) ?
                              COUNTDOWN_FRAMES : ROUNDOVER_FRAMES;
  localparam int CNT_W = $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0]   CD_LOAD   = CNT_W'(COUNTDOWN_FRAMES);
  localparam logic [CNT_W-1:0]   RO_LOAD   = CNT_W'(ROUNDOVER_FRAMES);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [2:0]         INFO_STOP = 3'b100;
  localparam logic [1:0]         HEAD_UP   = 2'b00;
  localparam logic [1:0]         HEAD_DOWN = 2'b01;

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    COUNTDOWN  = 3'b001,
    PLAY       = 3'b010,
    ROUND_OVER = 3'b011,
    GAME_OVER  = 3'b100
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       head1, head2;
  logic [1:0]       pend1, pend2;
  logic             pend1_v, pend2_v;
  logic             crash1_q, crash2_q;

  logic             acc1, acc2;
  logic             take1, take2;
  logic [1:0]       next1, next2;
  logic             c1, c2;
  logic             cnt_last;
  logic             win_reached;
  logic             enter_cd;
  logic [SCORE_W-1:0] s1_inc, s2_inc;

  // Reverse headings differ only in bit 0 (UP/DOWN, LEFT/RIGHT), so the
  // reverse of the committed heading is head ^ 01.
  always_comb begin
    acc1  = p1_dir_valid && !p1_dir_in[2] && (p1_dir_in[1:0] != (head1 ^ 2'b01));
    acc2  = p2_dir_valid && !p2_dir_in[2] && (p2_dir_in[1:0] != (head2 ^ 2'b01));
    // A request accepted in the tick cycle overrides the stored pending one.
    take1 = acc1 || pend1_v;
    take2 = acc2 || pend2_v;
    next1 = acc1 ? p1_dir_in[1:0] : pend1;
    next2 = acc2 ? p2_dir_in[1:0] : pend2;
    c1    = crash1_q || p1_crash;
    c2    = crash2_q || p2_crash;
    cnt_last    = (cnt == CNT_W'(1));
    win_reached = (p1_score == WIN) || (p2_score == WIN);
    s1_inc = (p1_score >= WIN) ? p1_score : p1_score + SCORE_W'(1);
    s2_inc = (p2_score >= WIN) ? p2_score : p2_score + SCORE_W'(1);
    enter_cd = ((state == IDLE || state == GAME_OVER) && start) ||
               (state == ROUND_OVER && frame_tick && cnt_last && !win_reached);
  end

  assign state_out = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      head1        <= HEAD_UP;
      head2        <= HEAD_DOWN;
      pend1        <= '0;
      pend2        <= '0;
      pend1_v      <= 1'b0;
      pend2_v      <= 1'b0;
      crash1_q     <= 1'b0;
      crash2_q     <= 1'b0;
      p1_score     <= '0;
      p2_score     <= '0;
      round_winner <= '0;
      dflt         <= 1'b1;
      p1_info      <= INFO_STOP;
      p2_info      <= INFO_STOP;
      game_over    <= 1'b0;
    end else begin
      case (state)
        COUNTDOWN: begin
          if (frame_tick) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt_last) begin
              state   <= PLAY;
              dflt    <= 1'b0;
              p1_info <= {1'b0, head1};
              p2_info <= {1'b0, head2};
            end
          end
        end
        PLAY: begin
          if (frame_tick) begin
            pend1_v  <= 1'b0;
            pend2_v  <= 1'b0;
            crash1_q <= 1'b0;
            crash2_q <= 1'b0;
            if (take1) head1 <= next1;
            if (take2) head2 <= next2;
            if (c1 || c2) begin
              state        <= ROUND_OVER;
              cnt          <= RO_LOAD;
              // {c1,c2} maps directly onto the winner code: 10 p2, 01 p1, 11 draw.
              round_winner <= {c1, c2};
              if (c1 && !c2) p2_score <= s2_inc;
              if (c2 && !c1) p1_score <= s1_inc;
              p1_info      <= INFO_STOP;
              p2_info      <= INFO_STOP;
            end else begin
              p1_info <= {1'b0, take1 ? next1 : head1};
              p2_info <= {1'b0, take2 ? next2 : head2};
            end
          end else begin
            if (acc1) begin
              pend1   <= p1_dir_in[1:0];
              pend1_v <= 1'b1;
            end
            if (acc2) begin
              pend2   <= p2_dir_in[1:0];
              pend2_v <= 1'b1;
            end
            crash1_q <= c1;
            crash2_q <= c2;
          end
        end
        ROUND_OVER: begin
          if (frame_tick) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt_last && win_reached) begin
              state     <= GAME_OVER;
              game_over <= 1'b1;
            end
          end
        end
        GAME_OVER: begin
          if (start) begin
            p1_score     <= '0;
            p2_score     <= '0;
            round_winner <= '0;
          end
        end
        default: ;
      endcase

      // Shared COUNTDOWN entry from IDLE, ROUND_OVER and GAME_OVER; later
      // assignments here take precedence over the per-state ones above.
      if (enter_cd) begin
        state     <= COUNTDOWN;
        cnt       <= CD_LOAD;
        head1     <= HEAD_UP;
        head2     <= HEAD_DOWN;
        pend1_v   <= 1'b0;
        pend2_v   <= 1'b0;
        dflt      <= 1'b1;
        p1_info   <= INFO_STOP;
        p2_info   <= INFO_STOP;
        game_over <= 1'b0;
      end
    end
  end

endmodule
